// File: rtl/usb_crc_tx_encoder.sv
// Serial CRC encoder for the USB TX path: PID, optional payload, then optional CRC5/CRC16, LSB-first.
// Latency: a packet offered in IDLE presents its first bit on the next cycle; one idle cycle between packets.
// Backpressure: a bit moves only when bs_ready is high; with bs_ready low, outputs and state hold.
//
// Ports:
//   clock, reset               single clock, synchronous active-high reset
//   pkt_ready/pkt_in/pkt_mode  packet offer: PID in [7:0], payload bytes above it, mode 0..3
//   pkt_len                    payload byte count for mode 2 (clamped to MAX_BYTES)
//   bs_ready                   bit stuffer accepts out_bit this cycle
//   out_bit/crc_valid_out      serial bit and its qualifier
//   last_bit                   final bit of the packet
//   busy                       packet in flight; further offers ignored
module usb_crc_tx_encoder #(
    parameter int MAX_BYTES = 8,
    localparam int LEN_W    = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pkt_ready,
    input  logic [8*MAX_BYTES+7:0] pkt_in,
    input  logic [1:0]             pkt_mode,
    input  logic [LEN_W-1:0]       pkt_len,
    input  logic                   bs_ready,
    output logic                   out_bit,
    output logic                   crc_valid_out,
    output logic                   last_bit,
    output logic                   busy
);
    localparam int PKT_W = 8*MAX_BYTES + 8;
    // Counts bits within one phase; must reach the longest body and 16 CRC bits.
    localparam int CNT_W = $clog2(8*MAX_BYTES + 17);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PID  = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;
    localparam logic [1:0] S_CRC  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] body_bits_q, body_bits_d;
    logic [PKT_W-1:0] pkt_q, pkt_d;
    logic [1:0]       mode_q, mode_d;
    logic [4:0]       crc5_q, crc5_d;
    logic [15:0]      crc16_q, crc16_d;

    logic [LEN_W-1:0] len_c;
    logic [CNT_W:0]   sel_idx;
    logic             pkt_bit;
    logic             cur_bit;
    logic             cur_last;
    logic             fb5;
    logic             fb16;

    assign len_c = (pkt_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : pkt_len;

    // Body bits sit 8 positions above the PID bits in the latched packet; a
    // mask-and-reduce select also yields 0 for positions past the vector end.
    assign sel_idx = (state_q == S_BODY) ? ({1'b0, cnt_q} + (CNT_W+1)'(8)) : {1'b0, cnt_q};
    assign pkt_bit = |(pkt_q & (PKT_W'(1) << sel_idx));

    always_comb begin
        cur_bit  = 1'b0;
        cur_last = 1'b0;
        case (state_q)
            S_PID: begin
                cur_bit  = pkt_bit;
                cur_last = (mode_q == 2'd0) && (cnt_q == CNT_W'(7));
            end
            S_BODY: begin
                cur_bit = pkt_bit;
            end
            S_CRC: begin
                // Complemented register, MSB first.
                if (mode_q == 2'd1) begin
                    cur_bit  = ~crc5_q[3'(3'd4 - cnt_q[2:0])];
                    cur_last = (cnt_q == CNT_W'(4));
                end else begin
                    cur_bit  = ~crc16_q[4'(4'd15 - cnt_q[3:0])];
                    cur_last = (cnt_q == CNT_W'(15));
                end
            end
            default: ;
        endcase
    end

    assign fb5  = crc5_q[4] ^ cur_bit;
    assign fb16 = crc16_q[15] ^ cur_bit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        body_bits_d = body_bits_q;
        pkt_d       = pkt_q;
        mode_d      = mode_q;
        crc5_d      = crc5_q;
        crc16_d     = crc16_q;
        case (state_q)
            S_IDLE: begin
                if (pkt_ready) begin
                    pkt_d   = pkt_in;
                    mode_d  = (pkt_mode == 2'd3) ? 2'd0 : pkt_mode;
                    if (pkt_mode == 2'd1)
                        body_bits_d = CNT_W'(11);
                    else if (pkt_mode == 2'd2)
                        body_bits_d = CNT_W'(len_c) << 3;
                    else
                        body_bits_d = '0;
                    crc5_d  = '1;
                    crc16_d = '1;
                    cnt_d   = '0;
                    state_d = S_PID;
                end
            end
            S_PID: begin
                if (bs_ready) begin
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d = '0;
                        if (mode_q == 2'd0)
                            state_d = S_IDLE;
                        else if (body_bits_q == '0)
                            state_d = S_CRC;
                        else
                            state_d = S_BODY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_BODY: begin
                if (bs_ready) begin
                    // Both registers run; only the one matching the mode is sent.
                    crc5_d  = {crc5_q[3:0], 1'b0} ^ (fb5 ? 5'h05 : 5'h00);
                    crc16_d = {crc16_q[14:0], 1'b0} ^ (fb16 ? 16'h8005 : 16'h0000);
                    if (cnt_q == body_bits_q - 1'b1) begin
                        cnt_d   = '0;
                        state_d = S_CRC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CRC: begin
                if (bs_ready) begin
                    if (cur_last)
                        state_d = S_IDLE;
                    else
                        cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            body_bits_q <= '0;
            pkt_q       <= '0;
            mode_q      <= 2'd0;
            crc5_q      <= '0;
            crc16_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            body_bits_q <= body_bits_d;
            pkt_q       <= pkt_d;
            mode_q      <= mode_d;
            crc5_q      <= crc5_d;
            crc16_q     <= crc16_d;
        end
    end

    assign crc_valid_out = (state_q != S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign out_bit       = cur_bit;
    assign last_bit      = cur_last;

endmodule
